// File: rtl/hbmc_pkg.sv
// Shared definitions for the HyperBus read-data recovery block.
//   SAMPLES : RWDS/DQ samples per ISERDES beat
//   DQ_W    : DQ bus width
//   byte_state_t : byte-pairing FSM states
//   dq_byte : gathers the DQ byte seen at a given sample position of a beat
package hbmc_pkg;

  localparam int SAMPLES = 6;
  localparam int DQ_W    = 8;

  typedef enum logic {
    EXPECT_HI = 1'b0,
    EXPECT_LO = 1'b1
  } byte_state_t;

  // Position 0 is the oldest sample, which sits in the MSB of each DQ lane.
  function automatic logic [DQ_W-1:0] dq_byte(input logic [SAMPLES*DQ_W-1:0] dq,
                                              input logic [2:0] pos);
    logic [DQ_W-1:0] b;
    for (int i = 0; i < DQ_W; i++)
      b[i] = dq[SAMPLES*i + (SAMPLES-1) - int'(pos)];
    return b;
  endfunction

endpackage

// File: rtl/hbmc_edge_finder.sv
// Finds RWDS transitions in one beat.
//   samples  : {s(-1), s(0) .. s(5)}, s(-1) is the last sample of the prior beat
//   e0_*     : first edge in time (valid, position, 1 = rising)
//   e1_*     : second edge in time
//   overflow : more than two edges in the beat
module hbmc_edge_finder
  import hbmc_pkg::*;
(
  input  logic [SAMPLES:0] samples,
  output logic             e0_valid,
  output logic [2:0]       e0_pos,
  output logic             e0_rise,
  output logic             e1_valid,
  output logic [2:0]       e1_pos,
  output logic             e1_rise,
  output logic             overflow
);

  logic [2:0] n_edges;

  always_comb begin
    e0_valid = 1'b0;
    e0_pos   = '0;
    e0_rise  = 1'b0;
    e1_valid = 1'b0;
    e1_pos   = '0;
    e1_rise  = 1'b0;
    n_edges  = '0;
    for (int p = 0; p < SAMPLES; p++) begin
      if (samples[SAMPLES-1-p] != samples[SAMPLES-p]) begin
        if (n_edges == 3'd0) begin
          e0_valid = 1'b1;
          e0_pos   = 3'(p);
          e0_rise  = samples[SAMPLES-1-p];
        end else if (n_edges == 3'd1) begin
          e1_valid = 1'b1;
          e1_pos   = 3'(p);
          e1_rise  = samples[SAMPLES-1-p];
        end
        n_edges = n_edges + 3'd1;
      end
    end
    overflow = (n_edges > 3'd2);
  end

endmodule

// File: rtl/hbmc_rx_recovery.sv
// Recovers 16-bit words from 6x-oversampled RWDS/DQ beats.
//   clk, rstn     : beat clock, synchronous active-low reset
//   en            : read-data phase enable
//   rwds_q, dq_q  : one oversampled beat per cycle (bit5 / lane MSB oldest)
//   word_data     : {rising byte, falling byte}, held between strobes
//   word_valid    : one-cycle strobe, two cycles after the beat holding the falling edge
//   word_cnt      : words since en rose
//   sync_err      : sticky edge-sequence violation
//   timeout       : sticky, no RWDS edge for TIMEOUT_CYCLES beats
module hbmc_rx_recovery
  import hbmc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic [SAMPLES-1:0]      rwds_q,
  input  logic [SAMPLES*DQ_W-1:0] dq_q,
  output logic [2*DQ_W-1:0]       word_data,
  output logic                    word_valid,
  output logic [15:0]             word_cnt,
  output logic                    sync_err,
  output logic                    timeout
);

  localparam logic [7:0] IDLE_MAX = 8'(TIMEOUT_CYCLES);

  logic [SAMPLES-1:0]      rwds_r;
  logic [SAMPLES*DQ_W-1:0] dq_r;
  logic                    s_m1_r;
  logic                    beat_v;
  logic                    en_d;
  logic [7:0]              idle_cnt;
  logic [7:0]              idle_nxt;
  byte_state_t             state;
  logic [DQ_W-1:0]         hi_byte;

  logic                    ev [2];
  logic [2:0]              ep [2];
  logic                    er [2];
  logic                    overflow;

  hbmc_edge_finder u_edges (
    .samples  ({s_m1_r, rwds_r}),
    .e0_valid (ev[0]),
    .e0_pos   (ep[0]),
    .e0_rise  (er[0]),
    .e1_valid (ev[1]),
    .e1_pos   (ep[1]),
    .e1_rise  (er[1]),
    .overflow (overflow)
  );

  // Idle tracking looks at the live beat so the flag lands one cycle after
  // the last quiet beat; rwds_r is cleared while disabled, which forces s(-1)=0.
  logic live_edge;
  assign live_edge = |({rwds_r[0], rwds_q[SAMPLES-1:1]} ^ rwds_q);

  always_comb begin
    if (live_edge)                idle_nxt = '0;
    else if (idle_cnt >= IDLE_MAX) idle_nxt = IDLE_MAX;
    else                          idle_nxt = idle_cnt + 8'd1;
  end

  // Walk the (at most two) edges of the registered beat in time order.
  byte_state_t     st_nxt;
  logic [DQ_W-1:0] hi_nxt;
  logic [DQ_W-1:0] cap_byte;
  logic [15:0]     word_nxt;
  logic            emit;
  logic            err;
  logic            active;

  assign active = en & beat_v;

  always_comb begin
    st_nxt   = state;
    hi_nxt   = hi_byte;
    cap_byte = '0;
    word_nxt = word_data;
    emit     = 1'b0;
    err      = overflow;
    for (int k = 0; k < 2; k++) begin
      if (ev[k]) begin
        // An edge on the last sample takes its byte from the beat now at the input.
        cap_byte = (ep[k] == 3'd5) ? dq_byte(dq_q, 3'd0) : dq_byte(dq_r, ep[k] + 3'd1);
        if (er[k]) begin
          if (st_nxt == EXPECT_LO) err = 1'b1;
          hi_nxt = cap_byte;
          st_nxt = EXPECT_LO;
        end else if (st_nxt == EXPECT_HI) begin
          err = 1'b1;
        end else begin
          emit     = 1'b1;
          word_nxt = {hi_nxt, cap_byte};
          st_nxt   = EXPECT_HI;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rwds_r     <= '0;
      dq_r       <= '0;
      s_m1_r     <= 1'b0;
      beat_v     <= 1'b0;
      en_d       <= 1'b0;
      idle_cnt   <= '0;
      state      <= EXPECT_HI;
      hi_byte    <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      word_cnt   <= '0;
      sync_err   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      en_d <= en;
      if (!en) begin
        rwds_r     <= '0;
        dq_r       <= '0;
        s_m1_r     <= 1'b0;
        beat_v     <= 1'b0;
        idle_cnt   <= '0;
        state      <= EXPECT_HI;
        hi_byte    <= '0;
        word_valid <= 1'b0;
      end else begin
        rwds_r     <= rwds_q;
        dq_r       <= dq_q;
        s_m1_r     <= rwds_r[0];
        beat_v     <= 1'b1;
        idle_cnt   <= idle_nxt;
        word_valid <= active & emit;
        if (active) begin
          state   <= st_nxt;
          hi_byte <= hi_nxt;
          if (emit) word_data <= word_nxt;
        end
        if (!en_d) begin
          word_cnt <= '0;
          sync_err <= 1'b0;
          timeout  <= (idle_nxt == IDLE_MAX);
        end else begin
          word_cnt <= word_cnt + 16'(active & emit);
          sync_err <= sync_err | (active & err);
          timeout  <= timeout | (idle_nxt == IDLE_MAX);
        end
      end
    end
  end

endmodule

// File: tb/tb_hbmc_rx_recovery.sv
module tb_hbmc_rx_recovery;

  localparam int T = 32;

  logic        clk = 1'b0;
  logic        rstn, en;
  logic [5:0]  rwds_q;
  logic [47:0] dq_q;
  logic [15:0] word_data, word_cnt;
  logic        word_valid, sync_err, timeout;

  int total = 0;
  int bad   = 0;

  hbmc_rx_recovery #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstn(rstn), .en(en), .rwds_q(rwds_q), .dq_q(dq_q),
    .word_data(word_data), .word_valid(word_valid), .word_cnt(word_cnt),
    .sync_err(sync_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: a short history of beats viewed as a flat sample stream.
  typedef struct { logic [5:0] r; logic [47:0] d; } beat_t;
  beat_t       q[$];
  logic        m_valid, m_err, m_to, m_lo, m_en_prev;
  logic [15:0] m_data, m_cnt;
  logic [7:0]  m_hi;
  int          m_idle;

  function automatic logic [7:0] pos_byte(input logic [47:0] d, input int p);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = d[6*i + 5 - p];
    return b;
  endfunction

  function automatic logic [47:0] mk_dq(input logic [7:0] p0, p1, p2, p3, p4, p5);
    logic [7:0]  pb [6];
    logic [47:0] d;
    pb = '{p0, p1, p2, p3, p4, p5};
    d = '0;
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < 8; i++) d[6*i + 5 - p] = pb[p][i];
    return d;
  endfunction

  function automatic bit has_edge(input logic sm1, input logic [5:0] r);
    logic prev;
    prev = sm1;
    for (int p = 0; p < 6; p++) begin
      if (r[5-p] != prev) return 1'b1;
      prev = r[5-p];
    end
    return 1'b0;
  endfunction

  task automatic eval_beat();
    int          n, seen;
    logic        s [7];
    logic [7:0]  pb [12];
    beat_t       cur, nxt;
    n   = q.size();
    cur = q[n-2];
    nxt = q[n-1];
    s[0] = (n >= 3) ? q[n-3].r[0] : 1'b0;
    for (int p = 0; p < 6; p++) begin
      s[p+1]  = cur.r[5-p];
      pb[p]   = pos_byte(cur.d, p);
      pb[p+6] = pos_byte(nxt.d, p);
    end
    seen = 0;
    for (int p = 0; p < 6; p++) begin
      if (s[p+1] != s[p]) begin
        seen++;
        if (seen > 2) m_err = 1'b1;
        else if (s[p+1]) begin
          if (m_lo) m_err = 1'b1;
          m_hi = pb[p+1];
          m_lo = 1'b1;
        end else if (!m_lo) begin
          m_err = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_data  = {m_hi, pb[p+1]};
          m_cnt   = m_cnt + 16'd1;
          m_lo    = 1'b0;
        end
      end
    end
  endtask

  task automatic model_step(input logic rs, input logic e, input logic [5:0] r, input logic [47:0] d);
    logic last;
    if (!rs) begin
      q.delete();
      m_valid = 0; m_err = 0; m_to = 0; m_lo = 0; m_data = 0; m_cnt = 0; m_hi = 0; m_idle = 0;
    end else if (!e) begin
      q.delete();
      m_valid = 0; m_lo = 0; m_hi = 0; m_idle = 0;
    end else begin
      if (!m_en_prev) begin m_cnt = 0; m_err = 0; m_to = 0; end
      last = (q.size() > 0) ? q[q.size()-1].r[0] : 1'b0;
      if (has_edge(last, r)) m_idle = 0;
      else if (m_idle < T) m_idle++;
      if (m_idle == T) m_to = 1'b1;
      q.push_back('{r: r, d: d});
      m_valid = 1'b0;
      if (q.size() >= 2) eval_beat();
      if (q.size() > 3) void'(q.pop_front());
    end
    m_en_prev = rs ? e : 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rs, input logic e, input logic [5:0] r, input logic [47:0] d);
    rstn = rs; en = e; rwds_q = r; dq_q = d;
    @(posedge clk);
    model_step(rs, e, r, d);
    #1;
    chk("valid", 32'(word_valid), 32'(m_valid));
    chk("data",  32'(word_data),  32'(m_data));
    chk("cnt",   32'(word_cnt),   32'(m_cnt));
    chk("err",   32'(sync_err),   32'(m_err));
    chk("tmo",   32'(timeout),    32'(m_to));
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, strobes;
    logic [7:0] hb, lb;
    rstn = 0; en = 0; rwds_q = '0; dq_q = '0;
    m_en_prev = 0;
    model_step(1'b0, 1'b0, '0, '0);

    // reset
    step(0, 0, 6'b111111, '1);
    step(0, 1, 6'b000111, '1);
    chk("reset_data", 32'(word_data), 0);
    chk("reset_cnt", 32'(word_cnt), 0);

    // basic word 0xA53C
    step(1, 1, 6'b000111, mk_dq(8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5));
    step(1, 1, 6'b000111, mk_dq(8'hA5, 8'h3C, 8'h3C, 8'h3C, 8'h00, 8'h00));
    step(1, 1, 6'b000111, '0);
    chk("basic_valid", 32'(word_valid), 1);
    chk("basic_word", 32'(word_data), 32'hA53C);
    chk("basic_cnt", 32'(word_cnt), 1);
    step(1, 1, 6'b111111, '0);

    // rising edge on the last sample of a beat
    step(1, 0, '0, '0);
    step(1, 1, 6'b000000, '0);
    step(1, 1, 6'b000001, '0);
    step(1, 1, 6'b110000, mk_dq(8'h5A, 8'h00, 8'h00, 8'hC3, 8'h00, 8'h00));
    step(1, 1, 6'b000000, '0);
    chk("p5_word", 32'(word_data), 32'h5AC3);
    chk("p5_valid", 32'(word_valid), 1);
    step(1, 1, 6'b000000, '0);
    chk("p5_hold", 32'(word_data), 32'h5AC3);
    chk("p5_cnt", 32'(word_cnt), 1);

    // falling edge while expecting the high byte, then recovery
    step(1, 0, '0, '0);
    step(1, 1, 6'b010111, '0);
    step(1, 1, 6'b000000, '0);
    step(1, 1, 6'b000111, mk_dq(8'h00, 8'h00, 8'h00, 8'h00, 8'h96, 8'h00));
    step(1, 1, 6'b111000, mk_dq(8'h00, 8'h00, 8'h00, 8'h00, 8'h69, 8'h00));
    chk("fall_hi_novalid", 32'(word_valid), 0);
    chk("fall_hi_err", 32'(sync_err), 1);
    step(1, 1, 6'b111111, '0);
    chk("recover_word", 32'(word_data), 32'h9669);
    chk("recover_valid", 32'(word_valid), 1);

    // 3x-oversampled burst of 256 words
    step(1, 0, '0, '0);
    w = 0; strobes = 0;
    for (int k = 0; k <= 258; k++) begin
      hb = 8'(k);
      lb = ~8'(k - 1);
      if (k <= 256)
        step(1, 1, 6'b000111, mk_dq(lb, lb, lb, hb, hb, hb));
      else
        step(1, 1, 6'b111111, '0);
      if (word_valid) begin
        chk("burst_order", 32'(word_data), {16'h0, 8'(w), ~8'(w)});
        w++; strobes++;
      end
    end
    chk("burst_strobes", 32'(strobes), 256);
    chk("burst_cnt", 32'(word_cnt), 256);
    chk("burst_err", 32'(sync_err), 0);

    // random beats with occasional enable drops and resets
    for (int k = 0; k < 600; k++)
      step(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 29) != 0),
           ($urandom_range(0, 1) != 0) ? 6'($urandom) : 6'b000111,
           {$urandom, 16'($urandom)});

    // idle timeout and clearing on en re-rise
    step(1, 0, '0, '0);
    for (int k = 1; k <= T; k++) begin
      step(1, 1, 6'b000000, '0);
      if (k == T - 1) chk("tmo_early", 32'(timeout), 0);
    end
    chk("tmo_set", 32'(timeout), 1);
    step(1, 0, '0, '0);
    chk("tmo_hold", 32'(timeout), 1);
    step(1, 1, 6'b000000, '0);
    chk("tmo_clear", 32'(timeout), 0);
    chk("err_clear", 32'(sync_err), 0);
    chk("cnt_clear", 32'(word_cnt), 0);

    // reset while holding a high byte
    step(1, 0, '0, '0);
    step(1, 1, 6'b000111, mk_dq(8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h11));
    step(1, 1, 6'b111111, '0);
    step(0, 1, 6'b111111, '0);
    chk("rst_valid", 32'(word_valid), 0);
    chk("rst_data", 32'(word_data), 0);
    chk("rst_cnt", 32'(word_cnt), 0);
    step(1, 1, 6'b000111, mk_dq(8'h00, 8'h00, 8'h00, 8'h00, 8'h77, 8'h00));
    chk("rst_after_valid", 32'(word_valid), 0);
    step(1, 1, 6'b111000, mk_dq(8'h00, 8'h00, 8'h00, 8'h00, 8'h88, 8'h00));
    step(1, 1, 6'b000000, '0);
    chk("rst_word", 32'(word_data), 32'h7788);
    chk("rst_word_cnt", 32'(word_cnt), 1);
    step(1, 1, 6'b000000, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
